// File: rtl/irq_pkg.sv
// Shared definitions for the button interrupt source: id width, FSM encoding, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package irq_pkg;

    // Width of irq_id / irq_ack_id on the core interrupt interface.
    localparam int IRQ_ID_W = 5;

    // Width of the internal source index (up to 16 sources).
    localparam int SRC_IDX_W = 4;

    // irq_id assigned to source 0 unless overridden.
    localparam int ID_BASE_DEFAULT = 16;

    // Request FSM: IDLE waits for work, REQ holds a request until acked,
    // GAP forces one deasserted cycle after each ack.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/btn_sync_debounce.sv
// Synchronises one raw button level and accepts it only after it has been stable.
// Latency: a stable change appears on level SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after first sampling.
// Backpressure: none; rise is a combinational pulse in the cycle level is about to go 0->1.
module btn_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 20
) (
    input  logic clk,
    input  logic res,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [DB_W-1:0]        cnt_q;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];

    // The synced level has differed from the accepted one long enough to take it.
    assign accept = (synced != level) && (cnt_q == CNT_LAST);
    assign rise   = accept && synced;

    // Metastability chain: raw enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            level <= 1'b0;
            cnt_q <= '0;
        end else if (synced == level) begin
            cnt_q <= '0;
        end else if (accept) begin
            level <= synced;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/button_irq_ctrl.sv
// Turns debounced button presses into prioritised level interrupts for the core.
// Latency: stable press -> pending after SYNC_STAGES+DEBOUNCE_CYCLES-1 edges, irq one edge later.
// Backpressure: a request is held until acked with its own id; one deasserted cycle follows each ack.
module button_irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int ID_BASE         = ID_BASE_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 20
) (
    input  logic                clk,
    input  logic                res,
    input  logic [N_SRC-1:0]    btn_in,
    input  logic [N_SRC-1:0]    irq_en,
    input  logic                irq_ack,
    input  logic [IRQ_ID_W-1:0] irq_ack_id,
    output logic                irq,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [N_SRC-1:0]    pending
);

    // Parameter sanity, caught at elaboration.
    if (ID_BASE + N_SRC - 1 > 31) begin : g_bad_id_range
        $error("button_irq_ctrl: ID_BASE+N_SRC-1 exceeds the 5-bit irq_id range");
    end
    if (N_SRC < 1 || N_SRC > 16) begin : g_bad_nsrc
        $error("button_irq_ctrl: N_SRC must be 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_irq_ctrl: SYNC_STAGES must be at least 2");
    end

    logic [N_SRC-1:0]     level_vec;
    logic [N_SRC-1:0]     rise_vec;
    logic [N_SRC-1:0]     set_vec;
    logic [N_SRC-1:0]     clr_vec;
    logic [N_SRC-1:0]     req_vec;
    logic                 enc_vld;
    logic [SRC_IDX_W-1:0] enc_idx;
    logic [SRC_IDX_W-1:0] idx_q;
    logic [SRC_IDX_W-1:0] idx_d;
    irq_state_e           state_q;
    irq_state_e           state_d;
    logic                 irq_d;
    logic [IRQ_ID_W-1:0]  irq_id_d;
    logic                 ack_take;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        btn_sync_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_W            (DB_W)
        ) u_db (
            .clk   (clk),
            .res   (res),
            .raw   (btn_in[i]),
            .level (level_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    // A press only counts while the accepted level is still low.
    assign set_vec = rise_vec & ~level_vec;
    assign req_vec = pending & irq_en;

    // Pending bits: a new press in the same cycle as its ack survives the clear.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    // Lowest enabled pending index wins.
    always_comb begin
        enc_vld = |req_vec;
        enc_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                enc_idx = SRC_IDX_W'(i);
            end
        end
    end

    // Clear mask for the source whose request was just acknowledged.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr_vec[i] = ack_take && (idx_q == SRC_IDX_W'(i));
        end
    end

    // FSM next state and registered outputs. GAP already provides the
    // deasserted cycle, so a waiting request is issued directly from it.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq;
        irq_id_d = irq_id;
        idx_d    = idx_q;
        ack_take = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    idx_d    = enc_idx;
                    irq_id_d = IRQ_ID_W'(ID_BASE) + IRQ_ID_W'(enc_idx);
                    irq_d    = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack && (irq_ack_id == irq_id)) begin
                    ack_take = 1'b1;
                    irq_d    = 1'b0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
                if (enc_vld) begin
                    idx_d    = enc_idx;
                    irq_id_d = IRQ_ID_W'(ID_BASE) + IRQ_ID_W'(enc_idx);
                    irq_d    = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers; reset clears outputs without a clock.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ST_IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            irq     <= irq_d;
            irq_id  <= irq_id_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_button_irq_ctrl.sv
module tb_button_irq_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic [3:0] btn_in;
    logic [3:0] irq_en;
    logic       irq_ack;
    logic [4:0] irq_ack_id;
    logic       irq;
    logic [4:0] irq_id;
    logic [3:0] pending;

    int checks   = 0;
    int failures = 0;

    button_irq_ctrl dut (
        .clk        (clk),
        .res        (res),
        .btn_in     (btn_in),
        .irq_en     (irq_en),
        .irq_ack    (irq_ack),
        .irq_ack_id (irq_ack_id),
        .irq        (irq),
        .irq_id     (irq_id),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle ack pulse for the given id.
    task automatic ack(input logic [4:0] id);
        irq_ack    = 1'b1;
        irq_ack_id = id;
        tick(1);
        irq_ack    = 1'b0;
        irq_ack_id = 5'd0;
    endtask

    task automatic test_reset;
        res        = 1'b1;
        btn_in     = 4'b0000;
        irq_en     = 4'hF;
        irq_ack    = 1'b0;
        irq_ack_id = 5'd0;
        #3;
        checks++;
        if (irq !== 1'b0 || irq_id !== 5'd0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state irq=%b id=%0d pending=%b want 0/0/0000", irq, irq_id, pending);
        end
        tick(2);
        res = 1'b0;
        tick(1);
    endtask

    task automatic test_single_press;
        btn_in = 4'b0001;
        tick(6);
        checks++;
        if (pending !== 4'b0001 || irq !== 1'b0) begin
            failures++;
            $display("FAIL single_edge5 pending=%b irq=%b want 0001/0", pending, irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd16) begin
            failures++;
            $display("FAIL single_edge6 irq=%b id=%0d want 1/16", irq, irq_id);
        end
        ack(5'd16);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL single_ack irq=%b pending=%b want 0/0000", irq, pending);
        end
        btn_in = 4'b0000;
        tick(8);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL single_release irq=%b pending=%b want 0/0000", irq, pending);
        end
    endtask

    task automatic test_glitch;
        logic seen_irq;
        seen_irq = 1'b0;
        btn_in = 4'b0001;
        tick(3);
        btn_in = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (irq !== 1'b0) seen_irq = 1'b1;
        end
        checks++;
        if (seen_irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL glitch irq_seen=%b pending=%b want 0/0000", seen_irq, pending);
        end
    endtask

    task automatic test_back_to_back;
        btn_in = 4'b0110;
        tick(7);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd17 || pending !== 4'b0110) begin
            failures++;
            $display("FAIL b2b_first irq=%b id=%0d pending=%b want 1/17/0110", irq, irq_id, pending);
        end
        ack(5'd17);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0100) begin
            failures++;
            $display("FAIL b2b_gap irq=%b pending=%b want 0/0100", irq, pending);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd18) begin
            failures++;
            $display("FAIL b2b_second irq=%b id=%0d want 1/18", irq, irq_id);
        end
        ack(5'd18);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_done irq=%b pending=%b want 0/0000", irq, pending);
        end
        btn_in = 4'b0000;
        tick(8);
    endtask

    task automatic test_bad_ack;
        btn_in = 4'b0001;
        tick(7);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd16) begin
            failures++;
            $display("FAIL badack_setup irq=%b id=%0d want 1/16", irq, irq_id);
        end
        ack(5'd20);
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd16 || pending !== 4'b0001) begin
            failures++;
            $display("FAIL badack_ignored irq=%b id=%0d pending=%b want 1/16/0001", irq, irq_id, pending);
        end
        ack(5'd16);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL badack_goodack irq=%b pending=%b want 0/0000", irq, pending);
        end
        btn_in = 4'b0000;
        tick(8);
    endtask

    task automatic test_mask;
        irq_en = 4'b0000;
        btn_in = 4'b1000;
        tick(8);
        checks++;
        if (pending !== 4'b1000 || irq !== 1'b0) begin
            failures++;
            $display("FAIL mask_held pending=%b irq=%b want 1000/0", pending, irq);
        end
        irq_en = 4'b1000;
        tick(1);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd19) begin
            failures++;
            $display("FAIL mask_enable irq=%b id=%0d want 1/19", irq, irq_id);
        end
        ack(5'd19);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL mask_ack irq=%b pending=%b want 0/0000", irq, pending);
        end
        irq_en = 4'hF;
        btn_in = 4'b0000;
        tick(8);
    endtask

    task automatic test_async_reset;
        btn_in = 4'b0001;
        tick(7);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd16) begin
            failures++;
            $display("FAIL arst_setup irq=%b id=%0d want 1/16", irq, irq_id);
        end
        #2;
        res    = 1'b1;
        btn_in = 4'b0000;
        #1;
        checks++;
        if (irq !== 1'b0 || irq_id !== 5'd0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL arst_immediate irq=%b id=%0d pending=%b want 0/0/0000", irq, irq_id, pending);
        end
        tick(2);
        res = 1'b0;
        tick(1);
        checks++;
        if (irq !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL arst_release irq=%b pending=%b want 0/0000", irq, pending);
        end
        btn_in = 4'b0010;
        tick(7);
        checks++;
        if (irq !== 1'b1 || irq_id !== 5'd17 || pending !== 4'b0010) begin
            failures++;
            $display("FAIL arst_idle_again irq=%b id=%0d pending=%b want 1/17/0010", irq, irq_id, pending);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_back_to_back();
        test_bad_ack();
        test_mask();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
